// File: rtl/sbox_share_sched_if.sv
`default_nettype none
// ============================================================================
//  Module      : sbox_share_sched_if
//  Description : Request/response bundle for the shared S-box scheduler.
//                Two independent requesters, each with its own valid/ready
//                request channel and its own valid/ready response channel:
//                  sb_* : 128-bit SubBytes jobs from the round datapath
//                  kw_* : 32-bit SubWord jobs from the key-expansion unit
//                Byte i of every data bus occupies bits [8i+7:8i].
//  Modports    : master - requester side (drives requests, consumes results)
//                slave  - scheduler side
//  Revision    : 1.0  initial release
// ============================================================================
interface sbox_share_sched_if;
  logic         sb_req_valid;
  logic         sb_req_ready;
  logic [127:0] sb_req_data;
  logic         sb_rsp_valid;
  logic         sb_rsp_ready;
  logic [127:0] sb_rsp_data;

  logic         kw_req_valid;
  logic         kw_req_ready;
  logic [31:0]  kw_req_data;
  logic         kw_rsp_valid;
  logic         kw_rsp_ready;
  logic [31:0]  kw_rsp_data;

  modport master (
    output sb_req_valid, sb_req_data, sb_rsp_ready,
    output kw_req_valid, kw_req_data, kw_rsp_ready,
    input  sb_req_ready, sb_rsp_valid, sb_rsp_data,
    input  kw_req_ready, kw_rsp_valid, kw_rsp_data
  );

  modport slave (
    input  sb_req_valid, sb_req_data, sb_rsp_ready,
    input  kw_req_valid, kw_req_data, kw_rsp_ready,
    output sb_req_ready, sb_rsp_valid, sb_rsp_data,
    output kw_req_ready, kw_rsp_valid, kw_rsp_data
  );
endinterface
`default_nettype wire

// File: rtl/sbox_share_sched.sv
`default_nettype none
// ============================================================================
//  Module      : sbox_share_sched (with helper module sbox)
//  Description : Time-multiplexes NUM_SBOX combinational AES S-box lookups
//                between a SubBytes requester (128-bit state) and a SubWord
//                requester (32-bit word). One chunk of NUM_SBOX bytes is
//                substituted in place per cycle; arbitration is round-robin
//                per job, starting with the key-expansion side after reset.
//  Parameters  : NUM_SBOX - S-box instances (1, 2 or 4)
//  Ports       : clk    - clock
//                rst_n  - asynchronous active-low reset
//                bus    - sbox_share_sched_if.slave request/response bundle
//                busy   - high whenever the scheduler is not idle
//  Options     : SBOX_SCHED_ZEROIZE_EN - when defined, the working register
//                is cleared on the response handshake so no result lingers.
//  Revision    : 1.0  initial release
// ============================================================================

// ----------------------------------------------------------------------------
//  sbox : single-byte AES forward S-box lookup (pure combinational ROM)
// ----------------------------------------------------------------------------
module sbox (
  input  wire  [7:0] i_data,
  output logic [7:0] o_data
);
  localparam logic [7:0] C_TABLE [256] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };

  assign o_data = C_TABLE[i_data];
endmodule

// ----------------------------------------------------------------------------
//  sbox_share_sched : job scheduler around the shared S-box bank
// ----------------------------------------------------------------------------
module sbox_share_sched #(
  parameter int NUM_SBOX = 4
) (
  input  wire                  clk,
  input  wire                  rst_n,
  sbox_share_sched_if.slave    bus,
  output logic                 busy
);
  // Chunk counts per job type; SubWord never needs fewer than one chunk.
  localparam int C_SB = 16 / NUM_SBOX;
  localparam int C_KW = (NUM_SBOX >= 4) ? 1 : (4 / NUM_SBOX);
  localparam int CW   = $clog2(C_SB);
  localparam logic [CW-1:0] C_SB_LAST = CW'(C_SB - 1);
  localparam logic [CW-1:0] C_KW_LAST = CW'(C_KW - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_SB   = 2'd1,
    OWN_KW   = 2'd2
  } owner_t;

  state_t          r_state;
  owner_t          r_owner;
  logic [CW-1:0]   r_cnt;
  logic [127:0]    r_work;
  logic            r_prio_sb;   // 1: SB wins a tie, 0: KW wins a tie

  logic            w_idle;
  logic            w_grant_sb;
  logic            w_grant_kw;
  logic            w_last;
  logic            w_rsp_hs;
  logic            w_sb_rsp_valid;
  logic            w_kw_rsp_valid;
  logic [127:0]    w_work_sub;
  logic [7:0]      w_sb_in  [NUM_SBOX];
  logic [7:0]      w_sb_out [NUM_SBOX];

  // --------------------------------------------------------------------------
  // Grant: only in IDLE, tie broken by the priority pointer. Gating with
  // rst_n keeps every output at 0 while reset is held, even with valids high.
  // --------------------------------------------------------------------------
  assign w_idle     = (r_state == ST_IDLE);
  assign w_grant_kw = rst_n & w_idle & bus.kw_req_valid &
                      (~bus.sb_req_valid | ~r_prio_sb);
  assign w_grant_sb = rst_n & w_idle & bus.sb_req_valid &
                      (~bus.kw_req_valid | r_prio_sb);

  assign bus.kw_req_ready = w_grant_kw;
  assign bus.sb_req_ready = w_grant_sb;

  // --------------------------------------------------------------------------
  // S-box lanes: lane k reads byte (r_cnt*NUM_SBOX + k) of the working reg.
  // A SubWord job only ever walks chunks covering bytes 0..3, so the upper
  // bytes of a KW job are never touched.
  // --------------------------------------------------------------------------
  for (genvar k = 0; k < NUM_SBOX; k++) begin : g_lane
    logic [3:0] w_idx;
    assign w_idx      = 4'(int'(r_cnt) * NUM_SBOX + k);
    assign w_sb_in[k] = r_work[{w_idx, 3'b000} +: 8];
    sbox u_sbox (
      .i_data (w_sb_in[k]),
      .o_data (w_sb_out[k])
    );
  end

  always_comb begin
    w_work_sub = r_work;
    for (int k = 0; k < NUM_SBOX; k++) begin
      w_work_sub[8*(int'(r_cnt)*NUM_SBOX + k) +: 8] = w_sb_out[k];
    end
  end

  assign w_last   = (r_owner == OWN_KW) ? (r_cnt == C_KW_LAST)
                                        : (r_cnt == C_SB_LAST);

  assign w_sb_rsp_valid = (r_state == ST_RESP) && (r_owner == OWN_SB);
  assign w_kw_rsp_valid = (r_state == ST_RESP) && (r_owner == OWN_KW);
  assign w_rsp_hs       = (w_sb_rsp_valid & bus.sb_rsp_ready) |
                          (w_kw_rsp_valid & bus.kw_rsp_ready);

  // --------------------------------------------------------------------------
  // Scheduler FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_owner   <= OWN_NONE;
      r_cnt     <= '0;
      r_work    <= '0;
      r_prio_sb <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_grant_kw) begin
            r_work    <= {96'd0, bus.kw_req_data};
            r_owner   <= OWN_KW;
            r_cnt     <= '0;
            r_state   <= ST_RUN;
            r_prio_sb <= 1'b1;
          end else if (w_grant_sb) begin
            r_work    <= bus.sb_req_data;
            r_owner   <= OWN_SB;
            r_cnt     <= '0;
            r_state   <= ST_RUN;
            r_prio_sb <= 1'b0;
          end
        end
        ST_RUN: begin
          r_work <= w_work_sub;
          // Counter parks on the last chunk instead of wrapping.
          if (w_last) begin
            r_state <= ST_RESP;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        ST_RESP: begin
          if (w_rsp_hs) begin
            r_state <= ST_IDLE;
            r_owner <= OWN_NONE;
`ifdef SBOX_SCHED_ZEROIZE_EN
            r_work  <= '0;
`endif
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_owner <= OWN_NONE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs: data is forced to 0 except for the owner while in RESP.
  // --------------------------------------------------------------------------
  assign bus.sb_rsp_valid = w_sb_rsp_valid;
  assign bus.kw_rsp_valid = w_kw_rsp_valid;
  assign bus.sb_rsp_data  = w_sb_rsp_valid ? r_work        : 128'd0;
  assign bus.kw_rsp_data  = w_kw_rsp_valid ? r_work[31:0]  : 32'd0;
  assign busy             = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_sbox_share_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sbox_share_sched
//  Description : Directed self-checking bench for sbox_share_sched. Expected
//                values are hand-computed AES S-box results.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sbox_share_sched;
  parameter int NUM_SBOX = 4;
  localparam int C_SB = 16 / NUM_SBOX;
  localparam int C_KW = (NUM_SBOX >= 4) ? 1 : (4 / NUM_SBOX);

  localparam logic [127:0] SB_VEC = 128'h0f0e0d0c0b0a09080706050403020100;
  localparam logic [127:0] SB_EXP = 128'h76abd7fe2b670130c56f6bf27b777c63;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic busy;

  int n_checks = 0;
  int n_errors = 0;

  sbox_share_sched_if bus ();

  sbox_share_sched #(.NUM_SBOX(NUM_SBOX)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_sb_req_ready"}, bus.sb_req_ready, 0);
    check({tag, "_kw_req_ready"}, bus.kw_req_ready, 0);
    check({tag, "_sb_rsp_valid"}, bus.sb_rsp_valid, 0);
    check({tag, "_kw_rsp_valid"}, bus.kw_rsp_valid, 0);
    check({tag, "_sb_rsp_data"},  bus.sb_rsp_data, 0);
    check({tag, "_kw_rsp_data"},  bus.kw_rsp_data, 0);
    check({tag, "_busy"},         busy, 0);
  endtask

  task automatic wait_idle(input string tag);
    int cyc = 0;
    while (busy && cyc < 100) begin
      tick();
      cyc++;
    end
    check({tag, "_idle_timeout"}, busy, 0);
  endtask

  // Single job with rsp_ready already high: checks grant, latency, data,
  // busy duration and that the other response port stays quiet.
  task automatic run_job(input bit is_kw, input logic [127:0] data,
                         input logic [127:0] exp, input int lat, input string tag);
    int cyc;
    int busy_cnt;
    logic rdy, vld;
    if (is_kw) begin
      bus.kw_req_valid = 1'b1;
      bus.kw_req_data  = data[31:0];
    end else begin
      bus.sb_req_valid = 1'b1;
      bus.sb_req_data  = data;
    end
    #1;
    cyc = 0;
    rdy = is_kw ? bus.kw_req_ready : bus.sb_req_ready;
    while (!rdy && cyc < 50) begin
      tick();
      cyc++;
      rdy = is_kw ? bus.kw_req_ready : bus.sb_req_ready;
    end
    check({tag, "_req_ready"}, rdy, 1);
    tick();
    bus.kw_req_valid = 1'b0;
    bus.sb_req_valid = 1'b0;
    cyc = 0;
    busy_cnt = 0;
    vld = is_kw ? bus.kw_rsp_valid : bus.sb_rsp_valid;
    while (!vld && cyc < 50) begin
      busy_cnt += int'(busy);
      tick();
      cyc++;
      vld = is_kw ? bus.kw_rsp_valid : bus.sb_rsp_valid;
    end
    busy_cnt += int'(busy);
    check({tag, "_latency"}, cyc, lat);
    check({tag, "_rsp_valid"}, vld, 1);
    if (is_kw) begin
      check({tag, "_rsp_data"}, bus.kw_rsp_data, exp);
      check({tag, "_other_valid"}, bus.sb_rsp_valid, 0);
      check({tag, "_other_data"}, bus.sb_rsp_data, 0);
    end else begin
      check({tag, "_rsp_data"}, bus.sb_rsp_data, exp);
      check({tag, "_other_valid"}, bus.kw_rsp_valid, 0);
      check({tag, "_other_data"}, bus.kw_rsp_data, 0);
    end
    check({tag, "_busy_cycles"}, busy_cnt, lat + 1);
    tick();
    check({tag, "_busy_after"}, busy, 0);
    check({tag, "_valid_after"}, is_kw ? bus.kw_rsp_valid : bus.sb_rsp_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic exp_kw;
    int cyc;
    bus.sb_req_valid = 1'b0;
    bus.sb_req_data  = '0;
    bus.kw_req_valid = 1'b0;
    bus.kw_req_data  = '0;
    bus.sb_rsp_ready = 1'b1;
    bus.kw_rsp_ready = 1'b1;

    // Reset state
    #3;
    check_all_zero("reset");
    check("reset_work", dut.r_work, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Both valid from the first IDLE: KW, SB, KW, SB
    bus.kw_req_valid = 1'b1;
    bus.kw_req_data  = 32'h01ff5300;
    bus.sb_req_valid = 1'b1;
    bus.sb_req_data  = SB_VEC;
    exp_kw = 1'b1;
    for (int g = 0; g < 4; g++) begin
      #1;
      cyc = 0;
      while (!(bus.kw_req_ready || bus.sb_req_ready) && cyc < 50) begin
        check("arb_both_ready", bus.kw_req_ready & bus.sb_req_ready, 0);
        tick();
        cyc++;
      end
      check($sformatf("arb_grant%0d", g), {bus.kw_req_ready, bus.sb_req_ready},
            {exp_kw, ~exp_kw});
      tick();
      exp_kw = ~exp_kw;
    end
    bus.kw_req_valid = 1'b0;
    bus.sb_req_valid = 1'b0;
    wait_idle("arb");
    tick();

    // Single-requester jobs
    run_job(1'b1, 128'h01ff5300, 128'h7c16ed63, C_KW, "kw_only");
    run_job(1'b0, SB_VEC, SB_EXP, C_SB, "sb_only");
`ifdef SBOX_SCHED_ZEROIZE_EN
    check("zeroize_work", dut.r_work, 0);
`else
    check("retain_work", dut.r_work, SB_EXP);
`endif
    run_job(1'b1, 128'hffffffff, 128'h16161616, C_KW, "kw_ff");

    // Response back-pressure with a KW request pending
    bus.sb_rsp_ready = 1'b0;
    bus.sb_req_valid = 1'b1;
    bus.sb_req_data  = SB_VEC;
    #1;
    check("hold_sb_ready", bus.sb_req_ready, 1);
    tick();
    bus.sb_req_valid = 1'b0;
    cyc = 0;
    while (!bus.sb_rsp_valid && cyc < 50) begin
      tick();
      cyc++;
    end
    bus.kw_req_valid = 1'b1;
    bus.kw_req_data  = 32'h00000000;
    #1;
    for (int i = 0; i < 10; i++) begin
      check($sformatf("hold_valid%0d", i), bus.sb_rsp_valid, 1);
      check($sformatf("hold_data%0d", i), bus.sb_rsp_data, SB_EXP);
      check($sformatf("hold_kw_ready%0d", i), bus.kw_req_ready, 0);
      tick();
    end
    bus.sb_rsp_ready = 1'b1;
    #1;
    check("hold_kw_ready_hs_cycle", bus.kw_req_ready, 0);
    tick();
    check("hold_sb_valid_after", bus.sb_rsp_valid, 0);
    check("hold_kw_ready_after", bus.kw_req_ready, 1);
    tick();
    bus.kw_req_valid = 1'b0;
    cyc = 0;
    while (!bus.kw_rsp_valid && cyc < 50) begin
      tick();
      cyc++;
    end
    check("hold_kw_data", bus.kw_rsp_data, 32'h63636363);
    tick();
    wait_idle("hold");

    // Reset in the second RUN cycle of an SB job
    bus.sb_req_valid = 1'b1;
    bus.sb_req_data  = SB_VEC;
    #1;
    check("rst_mid_ready", bus.sb_req_ready, 1);
    tick();
    bus.sb_req_valid = 1'b0;
    tick();
    check("rst_mid_busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    check_all_zero("rst_mid");
    check("rst_mid_work", dut.r_work, 0);
    tick();
    rst_n = 1'b1;
    tick();
    run_job(1'b1, 128'h0, 128'h63636363, C_KW, "kw_after_rst");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/sbox_share_sched.md
Name: sbox_share_sched

Overview:
- Time-multiplexes a small bank of combinational AES S-box lookups between two requesters.
  - The round datapath issues 128-bit SubBytes jobs.
  - The key-expansion unit issues 32-bit SubWord jobs.
- Instantiates NUM_SBOX `sbox` lookup instances internally and processes one chunk of NUM_SBOX bytes per cycle.
- Arbitrates round-robin between requesters at job granularity.
- Returns each result over its own valid/ready response channel.

Parameters:
- NUM_SBOX, 4, S-box instances; legal values 1, 2, 4. Chunk count C_SB = 16/NUM_SBOX; C_KW = max(1, 4/NUM_SBOX).

Ports:
- clk  in  1  clock; single clock domain
- rst_n  in  1  reset; asynchronous, active-low
- sb_req_valid  in  1  SubBytes job request
- sb_req_ready  out  1  SubBytes job accepted when valid&ready
- sb_req_data  in  128  state; byte i = bits [8i+7:8i]
- sb_rsp_valid  out  1  SubBytes result valid
- sb_rsp_ready  in  1  SubBytes result consumed
- sb_rsp_data  out  128  substituted state, same byte mapping
- kw_req_valid  in  1  SubWord job request
- kw_req_ready  out  1  SubWord job accepted
- kw_req_data  in  32  word; byte i = bits [8i+7:8i]
- kw_rsp_valid  out  1  SubWord result valid
- kw_rsp_ready  in  1  SubWord result consumed
- kw_rsp_data  out  32  substituted word
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, chunk counter=0, working register=0, owner=none, priority pointer=KW.
  - All outputs read 0.
- States: IDLE, RUN, RESP.
- IDLE:
  - Grant logic:
    - Exactly one request valid → grant it.
    - Both valid → grant the requester named by the priority pointer.
  - req_ready is high only for the granted requester, combinational from state and valids. Both readys are never high together.
  - On handshake:
    - Load req_data into the working register; KW loads the low 32 bits and upper bits are 0.
    - Set owner, counter=0, state→RUN.
    - Priority pointer → the other requester.
- RUN:
  - Each cycle, substitute bytes [counter*NUM_SBOX .. counter*NUM_SBOX+NUM_SBOX-1] in place and increment counter.
  - When owner=KW and NUM_SBOX=4, bytes ≥4 are not touched.
  - On the edge that processes the last chunk (C_SB-1 or C_KW-1), state→RESP.
- RESP:
  - The owner's rsp_valid=1, and its rsp_data = working register (KW: low 32 bits).
  - Valid and data stay stable until rsp_ready.
  - On the rsp_valid&rsp_ready edge, state→IDLE and owner=none.
  - The next job cannot be accepted in that same cycle; there is 1 idle cycle minimum between jobs.
- Latency: rsp_valid rises C cycles after the acceptance edge (NUM_SBOX=4: SB 4, KW 1). Throughput is 1 job per C+2 cycles with rsp_ready tied high.
- The non-owner's rsp_valid is 0.
- rsp_data for the non-owner, and for both ports outside RESP, is 0.
- Requesters hold valid and data stable until ready. Deasserting valid before ready is legal; no job is started.
- A request arriving during RUN/RESP is stalled (ready=0). It is not dropped.
- Reset mid-job: the job is discarded with no response, and the state returns to the reset values above.
- Counter width is clog2(C_SB); no wrap beyond the last chunk.

Optional Feature:
- Macro: SBOX_SCHED_ZEROIZE_EN.
- Defined:
  - The working register clears to 0 on the response-handshake edge.
  - With the macro defined, a stale result is never retained after delivery.
- Undefined:
  - The register holds the last result until the next job load.
  - Outputs are still gated to 0 outside RESP, so the port-level behaviour is identical.
  - The difference is visible only via an internal probe of the working register.

Test Plan:
- KW only, kw_req_data=32'h01ff5300, rsp_ready=1 → after 1 cycle kw_rsp_valid=1, kw_rsp_data=32'h7c16ed63; sb_rsp_valid stays 0.
- SB only, sb_req_data=128'h0f0e0d0c0b0a09080706050403020100 → after 4 cycles sb_rsp_data=128'h76abd7fe2b670130c56f6bf27b777c63; busy high for 5 cycles plus any hold in RESP.
- Both valid at the first IDLE after reset → KW granted first, then SB. Keep both asserted continuously → grants alternate KW, SB, KW, SB.
- Hold sb_rsp_ready=0 for 10 cycles in RESP → sb_rsp_valid and data stable. kw_req_valid asserted meanwhile → kw_req_ready stays 0 until 1 cycle after the SB response handshake.
- Assert rst_n=0 in the 2nd RUN cycle of an SB job → all outputs 0 immediately. After release, a new KW job with data 32'h00000000 returns 32'h63636363.
- NUM_SBOX=1 and 2 builds: repeat the SB vector → same result with latency 16 and 8. A KW job with 32'hffffffff returns 32'h16161616 with latency 4 and 2.
